// File: rtl/wash_pkg.sv
// Shared phase codes, selector encodings and lookup helpers for the wash sequencer.
// WASH_DRAIN_EN enables the DRAIN phase (code 7) in the sequencer.
package wash_pkg;

  typedef enum logic [2:0] {
    PH_IDLE  = 3'd0,
    PH_FILL  = 3'd1,
    PH_WASH  = 3'd2,
    PH_RINSE = 3'd3,
    PH_SPIN  = 3'd5,
    PH_XSPIN = 3'd6,
    PH_DRAIN = 3'd7
  } phase_t;

  typedef enum logic [1:0] {
    LOAD_S   = 2'd0,
    LOAD_M   = 2'd1,
    LOAD_L   = 2'd2,
    LOAD_BAD = 2'd3
  } load_t;

  typedef enum logic [1:0] {
    TEMP_HOT  = 2'd0,
    TEMP_WARM = 2'd1,
    TEMP_COLD = 2'd2,
    TEMP_BAD  = 2'd3
  } temp_t;

  // Seconds per phase for a given load size.
  function automatic int unsigned dwell_lookup(input load_t load,
                                               input int unsigned ds,
                                               input int unsigned dm,
                                               input int unsigned dl);
    case (load)
      LOAD_M:  return dm;
      LOAD_L:  return dl;
      default: return ds;
    endcase
  endfunction

  // A request of zero still runs one rinse pass.
  function automatic logic [1:0] rinse_clamp(input logic [1:0] req,
                                             input logic [1:0] max_r);
    if (req == 2'd0) return 2'd1;
    if (req > max_r) return max_r;
    return req;
  endfunction

endpackage

// File: rtl/wash_tick_gen.sv
// One-second tick prescaler: counts while enabled, holds when disabled, clears on clr.
module wash_tick_gen #(
  parameter int unsigned TICK_DIV = 16_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] TERM = PW'(TICK_DIV - 1);

  logic [PW-1:0] cnt_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else if (clr) begin
      cnt_reg <= '0;
    end else if (en) begin
      cnt_reg <= (cnt_reg == TERM) ? '0 : cnt_reg + 1'b1;
    end
  end

  assign tick = en & (cnt_reg == TERM);

endmodule

// File: rtl/wash_seq_ctrl.sv
// Washing-machine phase sequencer with pause, cancel, countdown and config error latch.
// Define WASH_DRAIN_EN to insert a DRAIN phase between WASH and RINSE.
module wash_seq_ctrl
  import wash_pkg::*;
#(
  parameter int unsigned TICK_DIV  = 16_000_000,
  parameter int unsigned CNT_W     = 4,
  parameter int unsigned DWELL_S   = 3,
  parameter int unsigned DWELL_M   = 5,
  parameter int unsigned DWELL_L   = 8,
  parameter int unsigned MAX_RINSE = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       load_sel,
  input  logic [1:0]       temp_sel,
  input  logic [1:0]       rinse_req,
  input  logic             xspin_req,
  input  logic             lid_open,
  input  logic             start_btn,
  input  logic             cancel_btn,
  output logic [2:0]       state_o,
  output logic [CNT_W-1:0] remaining_o,
  output logic [1:0]       rinse_idx_o,
  output logic             busy,
  output logic             paused,
  output logic             done_pulse,
  output logic             err
);

  localparam logic [1:0]       MAX_R = 2'(MAX_RINSE);
  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

  phase_t           state_reg, state_next;
  logic [CNT_W-1:0] remaining_reg, remaining_next;
  logic [1:0]       rinse_idx_reg, rinse_idx_next;
  logic [1:0]       rinse_cnt_reg, rinse_cnt_next;
  logic             xspin_reg, xspin_next;
  load_t            load_reg, load_next;
  logic             err_reg, err_next;
  logic             done_reg, done_next;
  logic             paused_reg, paused_next;
  logic             start_prev_reg;

  logic             start_edge;
  logic             cfg_ok;
  logic             phase_valid;
  logic             tick_en;
  logic             tick_clr;
  logic             tick;
  logic [CNT_W-1:0] dwell;
  logic [CNT_W-1:0] start_dwell;

  assign busy        = (state_reg != PH_IDLE);
  assign start_edge  = start_btn & ~start_prev_reg;
  assign cfg_ok      = (load_t'(load_sel) != LOAD_BAD) && (temp_t'(temp_sel) != TEMP_BAD);
  assign tick_en     = busy & ~lid_open;
  assign tick_clr    = ~busy;
  assign dwell       = CNT_W'(dwell_lookup(load_reg, DWELL_S, DWELL_M, DWELL_L));
  assign start_dwell = CNT_W'(dwell_lookup(load_t'(load_sel), DWELL_S, DWELL_M, DWELL_L));

  wash_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (tick_en),
    .clr   (tick_clr),
    .tick  (tick)
  );

  // Codes outside the active set (4, and 7 when DRAIN is not built) fall back to IDLE.
  always_comb begin
    case (state_reg)
      PH_FILL, PH_WASH, PH_RINSE, PH_SPIN, PH_XSPIN: phase_valid = 1'b1;
`ifdef WASH_DRAIN_EN
      PH_DRAIN: phase_valid = 1'b1;
`endif
      default: phase_valid = 1'b0;
    endcase
  end

  always_comb begin
    state_next     = state_reg;
    remaining_next = remaining_reg;
    rinse_idx_next = rinse_idx_reg;
    rinse_cnt_next = rinse_cnt_reg;
    xspin_next     = xspin_reg;
    load_next      = load_reg;
    err_next       = err_reg;
    done_next      = 1'b0;

    if (state_reg == PH_IDLE) begin
      remaining_next = '0;
      rinse_idx_next = '0;
      if (start_edge) begin
        if (!cfg_ok) begin
          err_next = 1'b1;
        end else if (!lid_open) begin
          err_next       = 1'b0;
          state_next     = PH_FILL;
          remaining_next = start_dwell;
          load_next      = load_t'(load_sel);
          rinse_cnt_next = rinse_clamp(rinse_req, MAX_R);
          xspin_next     = xspin_req;
        end
      end
    end else if (!phase_valid || cancel_btn) begin
      // Cancel has priority over any tick or pause in the same cycle.
      state_next     = PH_IDLE;
      remaining_next = '0;
      rinse_idx_next = '0;
    end else if (tick) begin
      if (remaining_reg != ONE) begin
        remaining_next = remaining_reg - ONE;
      end else begin
        remaining_next = dwell;
        case (state_reg)
          PH_FILL: state_next = PH_WASH;
          PH_WASH: begin
`ifdef WASH_DRAIN_EN
            state_next = PH_DRAIN;
`else
            state_next     = PH_RINSE;
            rinse_idx_next = 2'd1;
`endif
          end
`ifdef WASH_DRAIN_EN
          PH_DRAIN: begin
            state_next     = PH_RINSE;
            rinse_idx_next = 2'd1;
          end
`endif
          PH_RINSE: begin
            if (rinse_idx_reg >= rinse_cnt_reg) begin
              state_next     = PH_SPIN;
              rinse_idx_next = '0;
            end else begin
              rinse_idx_next = rinse_idx_reg + 2'd1;
            end
          end
          PH_SPIN: begin
            if (xspin_reg) begin
              state_next = PH_XSPIN;
            end else begin
              state_next     = PH_IDLE;
              remaining_next = '0;
              done_next      = 1'b1;
            end
          end
          default: begin
            state_next     = PH_IDLE;
            remaining_next = '0;
            rinse_idx_next = '0;
            done_next      = 1'b1;
          end
        endcase
      end
    end

    paused_next = (state_next != PH_IDLE) & lid_open;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= PH_IDLE;
      remaining_reg  <= '0;
      rinse_idx_reg  <= '0;
      rinse_cnt_reg  <= '0;
      xspin_reg      <= 1'b0;
      load_reg       <= LOAD_S;
      err_reg        <= 1'b0;
      done_reg       <= 1'b0;
      paused_reg     <= 1'b0;
      start_prev_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      remaining_reg  <= remaining_next;
      rinse_idx_reg  <= rinse_idx_next;
      rinse_cnt_reg  <= rinse_cnt_next;
      xspin_reg      <= xspin_next;
      load_reg       <= load_next;
      err_reg        <= err_next;
      done_reg       <= done_next;
      paused_reg     <= paused_next;
      start_prev_reg <= start_btn;
    end
  end

  assign state_o     = state_reg;
  assign remaining_o = remaining_reg;
  assign rinse_idx_o = rinse_idx_reg;
  assign paused      = paused_reg;
  assign done_pulse  = done_reg;
  assign err         = err_reg;

endmodule

// File: tb/tb_wash_seq_ctrl.sv
// Scoreboard bench for wash_seq_ctrl: expected phase records are queued at start and
// checked by a monitor as each phase is entered and left.
module tb_wash_seq_ctrl;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FILL  = 3'd1;
  localparam logic [2:0] S_WASH  = 3'd2;
  localparam logic [2:0] S_RINSE = 3'd3;
  localparam logic [2:0] S_SPIN  = 3'd5;
  localparam logic [2:0] S_XSPIN = 3'd6;
  localparam logic [2:0] S_DRAIN = 3'd7;

  logic       clk, rst_n;
  logic [1:0] load_sel, temp_sel, rinse_req;
  logic       xspin_req, lid_open, start_btn, cancel_btn;
  logic [2:0] state_o;
  logic [3:0] remaining_o;
  logic [1:0] rinse_idx_o;
  logic       busy, paused, done_pulse, err;

  wash_seq_ctrl #(.TICK_DIV(4)) dut (
    .clk(clk), .rst_n(rst_n), .load_sel(load_sel), .temp_sel(temp_sel),
    .rinse_req(rinse_req), .xspin_req(xspin_req), .lid_open(lid_open),
    .start_btn(start_btn), .cancel_btn(cancel_btn), .state_o(state_o),
    .remaining_o(remaining_o), .rinse_idx_o(rinse_idx_o), .busy(busy),
    .paused(paused), .done_pulse(done_pulse), .err(err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [2:0] st;
    logic [1:0] idx;
    int         len;
    int         rem;
    logic       done;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end else begin
      $display("ok   %s: %0d", tag, obs);
    end
  endtask

  task automatic push_exp(input logic [2:0] st, input logic [1:0] idx, input int len,
                          input int rem, input logic done);
    exp_t e;
    e.st = st; e.idx = idx; e.len = len; e.rem = rem; e.done = done;
    sb.push_back(e);
  endtask

  // FILL, WASH and (when built) DRAIN for one load size.
  task automatic push_head(input int rem, input int wash_len);
    push_exp(S_FILL, 2'd0, rem * 4, rem, 1'b0);
    push_exp(S_WASH, 2'd0, wash_len, rem, 1'b0);
`ifdef WASH_DRAIN_EN
    push_exp(S_DRAIN, 2'd0, rem * 4, rem, 1'b0);
`endif
  endtask

  // Monitor: one record per (state, rinse index) change.
  logic [2:0] mon_st  = 3'd0;
  logic [1:0] mon_idx = 2'd0;
  int         mon_cnt = 0;
  int         mon_len = -1;

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (state_o == mon_st && rinse_idx_o == mon_idx) begin
        mon_cnt++;
      end else begin
        if (mon_st != S_IDLE && mon_len >= 0)
          check_eq($sformatf("len_st%0d_i%0d", mon_st, mon_idx), mon_cnt, mon_len);
        if (sb.size() == 0) begin
          check_eq($sformatf("unexpected_st%0d", state_o), 1, 0);
          mon_len = -1;
        end else begin
          e = sb.pop_front();
          check_eq("phase_state", int'(state_o), int'(e.st));
          check_eq("phase_idx", int'(rinse_idx_o), int'(e.idx));
          check_eq("phase_rem", int'(remaining_o), e.rem);
          if (e.st == S_IDLE) check_eq("done_pulse", int'(done_pulse), int'(e.done));
          else check_eq("busy", int'(busy), 1);
          mon_len = e.len;
        end
        mon_st  = state_o;
        mon_idx = rinse_idx_o;
        mon_cnt = 1;
      end
    end
  end

  task automatic wait_state(input logic [2:0] st, input int budget, input string tag);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (state_o == st) return;
    end
    check_eq({"timeout_", tag}, int'(state_o), int'(st));
  endtask

  task automatic wait_idle(input int budget, input string tag);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!busy) begin
        repeat (2) @(negedge clk);
        return;
      end
    end
    check_eq({"timeout_", tag}, int'(busy), 0);
  endtask

  task automatic start_run(input logic [1:0] ld, input logic [1:0] rr, input logic xs);
    @(negedge clk);
    load_sel = ld; temp_sel = 2'd1; rinse_req = rr; xspin_req = xs; start_btn = 1'b1;
    @(negedge clk);
    start_btn = 1'b0;
  endtask

  initial begin
    int r;
    rst_n = 1'b0; load_sel = 2'd0; temp_sel = 2'd0; rinse_req = 2'd0;
    xspin_req = 1'b0; lid_open = 1'b0; start_btn = 1'b0; cancel_btn = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("reset_outs", int'({state_o, remaining_o, rinse_idx_o, busy, paused, done_pulse, err}), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 1: small load, rinse_req 0 -> one pass, no extra spin
    push_head(3, 12);
    push_exp(S_RINSE, 2'd1, 12, 3, 1'b0);
    push_exp(S_SPIN, 2'd0, 12, 3, 1'b0);
    push_exp(S_IDLE, 2'd0, -1, 0, 1'b1);
    start_run(2'd0, 2'd0, 1'b0);
    wait_idle(300, "t1");

    // 2: large load, three rinses, extra spin; config changed mid-run
    push_head(8, 32);
    push_exp(S_RINSE, 2'd1, 32, 8, 1'b0);
    push_exp(S_RINSE, 2'd2, 32, 8, 1'b0);
    push_exp(S_RINSE, 2'd3, 32, 8, 1'b0);
    push_exp(S_SPIN, 2'd0, 32, 8, 1'b0);
    push_exp(S_XSPIN, 2'd0, 32, 8, 1'b0);
    push_exp(S_IDLE, 2'd0, -1, 0, 1'b1);
    start_run(2'd2, 2'd3, 1'b1);
    repeat (3) @(negedge clk);
    load_sel = 2'd0; rinse_req = 2'd1; xspin_req = 1'b0;
    wait_idle(600, "t2");

    // 3: lid open for 50 cycles mid-WASH
    push_head(3, 62);
    push_exp(S_RINSE, 2'd1, 12, 3, 1'b0);
    push_exp(S_SPIN, 2'd0, 12, 3, 1'b0);
    push_exp(S_IDLE, 2'd0, -1, 0, 1'b1);
    start_run(2'd0, 2'd0, 1'b0);
    wait_state(S_WASH, 100, "t3_wash");
    repeat (5) @(negedge clk);
    r = int'(remaining_o);
    lid_open = 1'b1;
    repeat (2) @(negedge clk);
    check_eq("pause_paused", int'(paused), 1);
    check_eq("pause_state", int'(state_o), int'(S_WASH));
    check_eq("pause_rem", int'(remaining_o), r);
    repeat (48) @(negedge clk);
    check_eq("pause_rem_end", int'(remaining_o), r);
    lid_open = 1'b0;
    @(negedge clk);
    check_eq("resume_paused", int'(paused), 0);
    wait_idle(400, "t3");

    // 4: invalid load sets err; later valid start clears it
    @(negedge clk);
    load_sel = 2'd3; temp_sel = 2'd0; start_btn = 1'b1;
    @(negedge clk);
    check_eq("err_set", int'(err), 1);
    check_eq("err_busy", int'(busy), 0);
    start_btn = 1'b0;
    push_head(5, 20);
    push_exp(S_RINSE, 2'd1, 20, 5, 1'b0);
    push_exp(S_SPIN, 2'd0, 20, 5, 1'b0);
    push_exp(S_IDLE, 2'd0, -1, 0, 1'b1);
    @(negedge clk);
    load_sel = 2'd1; rinse_req = 2'd1; xspin_req = 1'b0; start_btn = 1'b1;
    @(negedge clk);
    check_eq("err_clear", int'(err), 0);
    start_btn = 1'b0;
    wait_idle(400, "t4");

    // 5: cancel during RINSE with start held high
    push_head(3, 12);
    push_exp(S_RINSE, 2'd1, -1, 3, 1'b0);
    push_exp(S_IDLE, 2'd0, -1, 0, 1'b0);
    @(negedge clk);
    load_sel = 2'd0; temp_sel = 2'd2; rinse_req = 2'd2; start_btn = 1'b1;
    wait_state(S_RINSE, 200, "t5_rinse");
    repeat (4) @(negedge clk);
    cancel_btn = 1'b1;
    @(negedge clk);
    check_eq("cancel_state", int'(state_o), int'(S_IDLE));
    check_eq("cancel_done", int'(done_pulse), 0);
    check_eq("cancel_rem", int'(remaining_o), 0);
    cancel_btn = 1'b0;
    repeat (20) @(negedge clk);
    check_eq("no_restart", int'(busy), 0);
    start_btn = 1'b0;
    repeat (2) @(negedge clk);

    // 6: async reset mid-SPIN
    push_head(3, 12);
    push_exp(S_RINSE, 2'd1, 12, 3, 1'b0);
    push_exp(S_SPIN, 2'd0, -1, 3, 1'b0);
    push_exp(S_IDLE, 2'd0, -1, 0, 1'b0);
    start_run(2'd0, 2'd0, 1'b0);
    wait_state(S_SPIN, 300, "t6_spin");
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_eq("async_reset_outs",
                int'({state_o, remaining_o, rinse_idx_o, busy, paused, done_pulse, err}), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("post_reset_idle", int'(state_o), int'(S_IDLE));

    check_eq("sb_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
